mc_control_unit: RTL and testbench

//  Multi-cycle MIPS32 main control FSM, next generation: parametrised ALU-op width, memory ready handshake
//  (wait states), BNE/ANDI/ORI/SLTI/JAL/JR support, retired-instruction counter. Drives the multi-cycle

---
 rtl/mc_control_unit_pkg.sv | 94 +++++++++
 rtl/mc_alu_decode.sv | 53 +++++
 rtl/mc_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared opcodes, funct codes, ALU ops, mux encodings and FSM states
// for the multi-cycle MIPS32 control unit.
package mc_control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_SRL = 6'h02;
    localparam logic [5:0] FUNC_JR  = 6'h08;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_XOR = 6'h26;
    localparam logic [5:0] FUNC_NOR = 6'h27;
    localparam logic [5:0] FUNC_SLT = 6'h2A;

    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_AND = 4'd2;
    localparam logic [3:0] ALUOP_OR  = 4'd3;
    localparam logic [3:0] ALUOP_XOR = 4'd4;
    localparam logic [3:0] ALUOP_NOR = 4'd5;
    localparam logic [3:0] ALUOP_SLT = 4'd6;
    localparam logic [3:0] ALUOP_SLL = 4'd7;
    localparam logic [3:0] ALUOP_SRL = 4'd8;

    localparam logic [2:0] SRCB_B    = 3'b000;
    localparam logic [2:0] SRCB_ZEXT = 3'b001;
    localparam logic [2:0] SRCB_SEXT = 3'b010;
    localparam logic [2:0] SRCB_SHL2 = 3'b011;
    localparam logic [2:0] SRCB_FOUR = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EXE_R    = 4'd2,
        S_EXE_I    = 4'd3,
        S_EXE_BR   = 4'd4,
        S_EXE_ADDR = 4'd5,
        S_EXE_J    = 4'd6,
        S_EXE_JR   = 4'd7,
        S_MEM_LW   = 4'd8,
        S_MEM_SW   = 4'd9,
        S_WB_R     = 4'd10,
        S_WB_I     = 4'd11,
        S_WB_LW    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    typedef struct packed {
        logic       ir_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation / operand-B select decode from op and func,
// plus illegal-instruction detection.
module mc_alu_decode
    import mc_control_unit_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic [2:0] alu_src_b,
    output logic       illegal
);

    always_comb begin
        alu_op    = ALUOP_ADD;
        alu_src_b = SRCB_B;
        illegal   = 1'b0;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                case (func)
                    FUNC_ADD: alu_op = ALUOP_ADD;
                    FUNC_SUB: alu_op = ALUOP_SUB;
                    FUNC_AND: alu_op = ALUOP_AND;
                    FUNC_OR:  alu_op = ALUOP_OR;
                    FUNC_XOR: alu_op = ALUOP_XOR;
                    FUNC_NOR: alu_op = ALUOP_NOR;
                    FUNC_SLT: alu_op = ALUOP_SLT;
                    FUNC_SLL: alu_op = ALUOP_SLL;
                    FUNC_SRL: alu_op = ALUOP_SRL;
                    FUNC_JR:  alu_op = ALUOP_ADD;
                    default:  illegal = 1'b1;
                endcase
            end
            (op == OP_ADDI): alu_src_b = SRCB_SEXT;
            (op == OP_SLTI): begin
                alu_src_b = SRCB_SEXT;
                alu_op    = ALUOP_SLT;
            end
            (op == OP_ANDI): begin
                alu_src_b = SRCB_ZEXT;
                alu_op    = ALUOP_AND;
            end
            (op == OP_ORI): begin
                alu_src_b = SRCB_ZEXT;
                alu_op    = ALUOP_OR;
            end
            (op == OP_BEQ || op == OP_BNE): alu_op = ALUOP_SUB;
            (op == OP_LW || op == OP_SW): alu_src_b = SRCB_SEXT;
            (op == OP_J || op == OP_JAL): alu_op = ALUOP_ADD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS32 main control FSM with memory wait states.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal instructions.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               a_write,
    output logic               b_write,
    output logic               alu_out_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [2:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count,
    output logic               illegal_op
);

    state_e     state;
    state_e     nxt;
    ctrl_t      c;
    logic       retire;
    logic [3:0] dec_op;
    logic [2:0] dec_srcb;
    logic       dec_illegal;

    mc_alu_decode u_dec (
        .op        (op),
        .func      (func),
        .alu_op    (dec_op),
        .alu_src_b (dec_srcb),
        .illegal   (dec_illegal)
    );

    always_comb begin
        nxt = S_IF;
        case (state)
            S_IF: nxt = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    nxt = S_TRAP;
`else
                    nxt = S_IF;
`endif
                end else begin
                    unique case (1'b1)
                        (op == OP_RTYPE):
                            nxt = (func == FUNC_JR) ? S_EXE_JR : S_EXE_R;
                        (op == OP_BEQ || op == OP_BNE): nxt = S_EXE_BR;
                        (op == OP_LW || op == OP_SW):   nxt = S_EXE_ADDR;
                        (op == OP_J || op == OP_JAL):   nxt = S_EXE_J;
                        default:                        nxt = S_EXE_I;
                    endcase
                end
            end
            S_EXE_R:    nxt = S_WB_R;
            S_EXE_I:    nxt = S_WB_I;
            S_EXE_ADDR: nxt = (op == OP_LW) ? S_MEM_LW : S_MEM_SW;
            S_MEM_LW:   nxt = mem_ready ? S_WB_LW : S_MEM_LW;
            S_MEM_SW:   nxt = mem_ready ? S_IF : S_MEM_SW;
            default:    nxt = S_IF;
        endcase
    end

    // A trap is an abandoned instruction, so it never counts as retired.
    assign retire = (nxt == S_IF) && (state != S_IF) && (state != S_TRAP);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IF;
            instr_count <= '0;
        end else begin
            state <= nxt;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        c = '0;
        if (nrst) begin
            case (state)
                S_IF: begin
                    c.mem_read  = 1'b1;
                    c.alu_src_b = SRCB_FOUR;
                    c.ir_write  = mem_ready;
                    c.pc_write  = mem_ready;
                end
                S_ID: begin
                    c.a_write       = 1'b1;
                    c.b_write       = 1'b1;
                    c.alu_out_write = 1'b1;
                    c.alu_src_b     = SRCB_SHL2;
                end
                S_EXE_R, S_EXE_I: begin
                    c.alu_src_a = 1'b1;
                    c.alu_src_b = dec_srcb;
                    c.alu_op    = dec_op;
                end
                S_EXE_BR: begin
                    c.alu_src_a = 1'b1;
                    c.alu_op    = ALUOP_SUB;
                    c.pc_src    = PCSRC_ALUOUT;
                    c.pc_write  = (op == OP_BEQ) ? zero : ~zero;
                end
                S_EXE_ADDR: begin
                    c.alu_src_a     = 1'b1;
                    c.alu_src_b     = SRCB_SEXT;
                    c.alu_out_write = 1'b1;
                end
                S_EXE_J: begin
                    c.pc_src   = PCSRC_JUMP;
                    c.pc_write = 1'b1;
                    if (op == OP_JAL) begin
                        c.reg_write  = 1'b1;
                        c.reg_dst    = REGDST_RA;
                        c.mem_to_reg = M2R_PC;
                    end
                end
                // JR encodes rt=$0, so A + B passes rs straight to the PC.
                S_EXE_JR: begin
                    c.alu_src_a = 1'b1;
                    c.pc_src    = PCSRC_ALU;
                    c.pc_write  = 1'b1;
                end
                S_MEM_LW: begin
                    c.iord      = 1'b1;
                    c.mem_read  = 1'b1;
                    c.mdr_write = mem_ready;
                end
                S_MEM_SW: begin
                    c.iord      = 1'b1;
                    c.mem_write = 1'b1;
                end
                S_WB_R: begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = REGDST_RD;
                end
                S_WB_I: c.reg_write = 1'b1;
                S_WB_LW: begin
                    c.reg_write  = 1'b1;
                    c.mem_to_reg = M2R_MDR;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    c.pc_src     = PCSRC_TRAP;
                    c.pc_write   = 1'b1;
                    c.illegal_op = 1'b1;
                end
`endif
                default: c = '0;
            endcase
        end
    end

    assign ir_write      = c.ir_write;
    assign mdr_write     = c.mdr_write;
    assign a_write       = c.a_write;
    assign b_write       = c.b_write;
    assign alu_out_write = c.alu_out_write;
    assign reg_write     = c.reg_write;
    assign reg_dst       = c.reg_dst;
    assign mem_to_reg    = c.mem_to_reg;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign alu_op        = ALUOP_W'(c.alu_op);
    assign pc_src        = c.pc_src;
    assign pc_write      = c.pc_write;
    assign iord          = c.iord;
    assign mem_read      = c.mem_read;
    assign mem_write     = c.mem_write;
    assign illegal_op    = c.illegal_op;
    assign instr_done    = nrst & retire;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction table with a retire
// scoreboard plus wait-state, illegal-op and reset sequences.
module tb_mc_control_unit;

    logic        clk;
    logic        nrst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        mem_ready;
    logic        ir_write, mdr_write, a_write, b_write;
    logic        alu_out_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, pc_src;
    logic        alu_src_a;
    logic [2:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        pc_write, iord, mem_read, mem_write;
    logic        instr_done, illegal_op;
    logic [31:0] instr_count;
    logic [25:0] all_out;

    mc_control_unit #(.ALUOP_W(4), .CNT_W(32)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .op            (op),
        .func          (func),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .a_write       (a_write),
        .b_write       (b_write),
        .alu_out_write (alu_out_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .instr_done    (instr_done),
        .instr_count   (instr_count),
        .illegal_op    (illegal_op)
    );

    assign all_out = {ir_write, mdr_write, a_write, b_write,
                      alu_out_write, reg_write, reg_dst, mem_to_reg,
                      alu_src_a, alu_src_b, alu_op, pc_src, pc_write,
                      iord, mem_read, mem_write, instr_done, illegal_op};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        logic       zero;
        int         cycles;
        bit         ec;
        logic [3:0] e_aluop;
        logic [2:0] e_srcb;
        logic       e_srca;
        logic       d_rw;
        logic [1:0] d_rd;
        logic [1:0] d_m2r;
        logic [1:0] d_pcsrc;
        logic       d_pcw;
    } vec_t;

    vec_t tbl[19];
    vec_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   model_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t mk(input string n, input logic [5:0] o,
        input logic [5:0] f, input logic z, input int cy, input bit ec,
        input logic [3:0] ea, input logic [2:0] eb, input logic esa,
        input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
        input logic [1:0] ps, input logic pw);
        vec_t v;
        v.name = n; v.op = o; v.func = f; v.zero = z; v.cycles = cy;
        v.ec = ec; v.e_aluop = ea; v.e_srcb = eb; v.e_srca = esa;
        v.d_rw = rw; v.d_rd = rd; v.d_m2r = m2r; v.d_pcsrc = ps;
        v.d_pcw = pw;
        return v;
    endfunction

    // Starts at a negedge with the FSM in S_IF; mem_ready is low for
    // cycles wlo..whi-1, and memory strobes are checked wlo..whi.
    task automatic run_vec(input vec_t v, input int wlo, input int whi);
        vec_t e;
        bit   done;
        logic is_lw;
        done  = 0;
        is_lw = (v.op == 6'h23);
        op = v.op; func = v.func; zero = v.zero;
        q.push_back(v);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            mem_ready = !(cyc >= wlo && cyc < whi);
            #1;
            if (v.ec && cyc == 2) begin
                chk($sformatf("%s.alu_op", v.name), 32'(alu_op), 32'(v.e_aluop));
                chk($sformatf("%s.srcb", v.name), 32'(alu_src_b), 32'(v.e_srcb));
                chk($sformatf("%s.srca", v.name), 32'(alu_src_a), 32'(v.e_srca));
            end
            if (whi > wlo && cyc >= wlo && cyc <= whi)
                chk($sformatf("%s.mem%0d", v.name, cyc),
                    32'({mem_read, mem_write, iord, mdr_write,
                         ir_write, pc_write, alu_out_write}),
                    32'({is_lw, !is_lw, 1'b1, is_lw && cyc == whi,
                         1'b0, 1'b0, 1'b0}));
            if (instr_done) begin
                done = 1;
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL %s.sb: got done want empty queue", v.name);
                end else begin
                    e = q.pop_front();
                    model_cnt++;
                    chk($sformatf("%s.cycles", e.name), cyc + 1, e.cycles);
                    chk($sformatf("%s.wb", e.name),
                        32'({reg_write, reg_dst, mem_to_reg, pc_src, pc_write}),
                        32'({e.d_rw, e.d_rd, e.d_m2r, e.d_pcsrc, e.d_pcw}));
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            $display("FAIL %s.timeout: got no instr_done want done", v.name);
        end
        chk($sformatf("%s.count", v.name), instr_count, model_cnt);
    endtask

    task automatic run_illegal(input string nm, input logic [5:0] o,
                               input logic [5:0] f);
        op = o; func = f; zero = 1'b0; mem_ready = 1'b1;
        #1;
        @(negedge clk);
        #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk({nm, ".id"}, 32'({instr_done, illegal_op}), 0);
        @(negedge clk);
        #1;
        chk({nm, ".trap"}, 32'({illegal_op, pc_src, pc_write, instr_done}),
            32'({1'b1, 2'b11, 1'b1, 1'b0}));
`else
        chk({nm, ".id"}, 32'({instr_done, illegal_op}), 32'({1'b1, 1'b0}));
        model_cnt++;
`endif
        @(negedge clk);
        chk({nm, ".count"}, instr_count, model_cnt);
    endtask

    initial begin
        tbl[0]  = mk("add",  6'h00, 6'h20, 0, 4, 1, 0, 3'b000, 1, 1, 2'b01, 2'b00, 2'b00, 0);
        tbl[1]  = mk("sub",  6'h00, 6'h22, 0, 4, 1, 1, 3'b000, 1, 1, 2'b01, 2'b00, 2'b00, 0);
        tbl[2]  = mk("slt",  6'h00, 6'h2A, 0, 4, 1, 6, 3'b000, 1, 1, 2'b01, 2'b00, 2'b00, 0);
        tbl[3]  = mk("srl",  6'h00, 6'h02, 0, 4, 1, 8, 3'b000, 1, 1, 2'b01, 2'b00, 2'b00, 0);
        tbl[4]  = mk("nor",  6'h00, 6'h27, 0, 4, 1, 5, 3'b000, 1, 1, 2'b01, 2'b00, 2'b00, 0);
        tbl[5]  = mk("ori",  6'h0D, 6'h00, 0, 4, 1, 3, 3'b001, 1, 1, 2'b00, 2'b00, 2'b00, 0);
        tbl[6]  = mk("andi", 6'h0C, 6'h00, 0, 4, 1, 2, 3'b001, 1, 1, 2'b00, 2'b00, 2'b00, 0);
        tbl[7]  = mk("slti", 6'h0A, 6'h00, 0, 4, 1, 6, 3'b010, 1, 1, 2'b00, 2'b00, 2'b00, 0);
        tbl[8]  = mk("addi", 6'h08, 6'h00, 0, 4, 1, 0, 3'b010, 1, 1, 2'b00, 2'b00, 2'b00, 0);
        tbl[9]  = mk("beq1", 6'h04, 6'h00, 1, 3, 1, 1, 3'b000, 1, 0, 2'b00, 2'b00, 2'b01, 1);
        tbl[10] = mk("beq0", 6'h04, 6'h00, 0, 3, 1, 1, 3'b000, 1, 0, 2'b00, 2'b00, 2'b01, 0);
        tbl[11] = mk("bne1", 6'h05, 6'h00, 1, 3, 1, 1, 3'b000, 1, 0, 2'b00, 2'b00, 2'b01, 0);
        tbl[12] = mk("bne0", 6'h05, 6'h00, 0, 3, 1, 1, 3'b000, 1, 0, 2'b00, 2'b00, 2'b01, 1);
        tbl[13] = mk("jal",  6'h03, 6'h00, 0, 3, 0, 0, 3'b000, 0, 1, 2'b10, 2'b10, 2'b10, 1);
        tbl[14] = mk("j",    6'h02, 6'h00, 0, 3, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 2'b10, 1);
        tbl[15] = mk("jr",   6'h00, 6'h08, 0, 3, 1, 0, 3'b000, 1, 0, 2'b00, 2'b00, 2'b00, 1);
        tbl[16] = mk("sw",   6'h2B, 6'h00, 0, 4, 1, 0, 3'b010, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        tbl[17] = mk("lw",   6'h23, 6'h00, 0, 5, 1, 0, 3'b010, 1, 1, 2'b00, 2'b01, 2'b00, 0);
        tbl[18] = mk("add2", 6'h00, 6'h20, 0, 4, 1, 0, 3'b000, 1, 1, 2'b01, 2'b00, 2'b00, 0);

        nrst = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.outs", 32'(all_out), 0);
        chk("rst.count", instr_count, 0);
        nrst = 1'b1; mem_ready = 1'b0;
        #1;
        chk("if.wait", 32'({mem_read, iord, alu_src_b, alu_op, ir_write, pc_write}),
            32'({1'b1, 1'b0, 3'b100, 4'd0, 1'b0, 1'b0}));
        @(negedge clk);

        for (int i = 0; i < 18; i++)
            run_vec(tbl[i], 99, 99);

        begin
            vec_t lw8, sw6;
            lw8 = tbl[17]; lw8.name = "lw_wait"; lw8.cycles = 8;
            sw6 = tbl[16]; sw6.name = "sw_wait"; sw6.cycles = 6;
            run_vec(lw8, 3, 6);
            run_vec(sw6, 3, 5);
        end

        run_illegal("ill_op", 6'h3F, 6'h00);
        run_illegal("ill_fn", 6'h00, 6'h3F);

        mem_ready = 1'b0;
        #1;
        chk("ifw1", 32'({ir_write, pc_write, mem_read}), 32'(3'b001));
        @(negedge clk);
        #1;
        chk("ifw2", 32'({ir_write, pc_write, mem_read}), 32'(3'b001));
        #2;
        nrst = 1'b0;
        #1;
        chk("async.outs", 32'(all_out), 0);
        chk("async.count", instr_count, 0);
        model_cnt = 0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rel.if", 32'({mem_read, iord, alu_src_b, ir_write}),
            32'({1'b1, 1'b0, 3'b100, 1'b0}));
        chk("rel.count", instr_count, 0);
        @(negedge clk);
        run_vec(tbl[18], 99, 99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
